// File: rtl/boreal_vec_mem_bridge_if.sv
// Client/SRAM bundle for boreal_vec_mem_bridge: two vector ports, one host port and the SRAM macro port.
// The master modport is the bridge side; slave is the side of the clients and the SRAM.
interface boreal_vec_mem_bridge_if #(
  parameter int unsigned MEM_AW = 12
);
  logic              vec_rd_req;
  logic [31:0]       vec_rd_addr;
  logic [31:0]       vec_rd_data;
  logic              vec_rd_ack;
  logic              vec_wr_req;
  logic [31:0]       vec_wr_addr;
  logic [31:0]       vec_wr_data;
  logic              vec_wr_ack;
  logic              host_req;
  logic              host_we;
  logic [31:0]       host_addr;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic              host_ack;
  logic              mem_cs;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              err;

  modport master (
    input  vec_rd_req, vec_rd_addr, vec_wr_req, vec_wr_addr, vec_wr_data,
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output vec_rd_data, vec_rd_ack, vec_wr_ack, host_rdata, host_ack,
    output mem_cs, mem_we, mem_addr, mem_wdata, err
  );

  modport slave (
    output vec_rd_req, vec_rd_addr, vec_wr_req, vec_wr_addr, vec_wr_data,
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  vec_rd_data, vec_rd_ack, vec_wr_ack, host_rdata, host_ack,
    input  mem_cs, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/boreal_vec_mem_bridge.sv
// Three-client arbiter onto one single-port SRAM, one access per 4 cycles (IDLE/ACCESS/RESP/HOLD).
// Optional range checking with sticky err is enabled by defining BOREAL_VMB_BOUNDS_EN.
module boreal_vec_mem_bridge #(
  parameter int unsigned MEM_AW   = 12,
  parameter logic [31:0] MEM_BASE = 32'h2000_0000,
  parameter int unsigned HOST_AGE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  boreal_vec_mem_bridge_if.master bus
);
  localparam int unsigned AGE_W = $clog2(HOST_AGE + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_HOLD} state_e;
  typedef enum logic [1:0] {C_WR, C_RD, C_HOST} client_e;

  state_e            state_q, state_d;
  client_e           gnt_q, gnt_d;
  logic              excl_vld_q, excl_vld_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              is_rd_q, is_rd_d;
  logic              oob_q, oob_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              host_ack_q, host_ack_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [31:0]       host_rdata_q, host_rdata_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              err_q, err_d;

  logic              wr_ok, rd_ok, host_ok, any_ok;
  client_e           win;
  logic [31:0]       sel_addr, sel_wdata, resp_data;
  logic              sel_we, sel_oob;
  logic [MEM_AW-1:0] sel_word;

  // The client acked in the last slot is masked for the first IDLE cycle, so a
  // request it is still dropping cannot be served a second time.
  always_comb begin
    wr_ok   = bus.vec_wr_req && !(excl_vld_q && gnt_q == C_WR);
    rd_ok   = bus.vec_rd_req && !(excl_vld_q && gnt_q == C_RD);
    host_ok = bus.host_req   && !(excl_vld_q && gnt_q == C_HOST);
    any_ok  = wr_ok || rd_ok || host_ok;
    if (host_ok && age_q == AGE_W'(HOST_AGE)) win = C_HOST;
    else if (wr_ok)                           win = C_WR;
    else if (rd_ok)                           win = C_RD;
    else                                      win = C_HOST;

    sel_addr  = bus.vec_wr_addr;
    sel_wdata = bus.vec_wr_data;
    sel_we    = 1'b1;
    case (win)
      C_RD: begin
        sel_addr = bus.vec_rd_addr;
        sel_we   = 1'b0;
      end
      C_HOST: begin
        sel_addr  = bus.host_addr;
        sel_wdata = bus.host_wdata;
        sel_we    = bus.host_we;
      end
      default: ;
    endcase
  end

`ifdef BOREAL_VMB_BOUNDS_EN
  logic [32:0] off_ext;
  assign off_ext  = {1'b0, sel_addr} - {1'b0, MEM_BASE};
  assign sel_oob  = off_ext[32] || ((off_ext[31:0] >> (MEM_AW + 2)) != 32'd0);
  assign sel_word = off_ext[MEM_AW+1:2];
`else
  assign sel_oob  = 1'b0;
  assign sel_word = MEM_AW'((sel_addr - MEM_BASE) >> 2);
`endif

  assign resp_data = oob_q ? 32'hDEAD_BEEF : bus.mem_rdata;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    excl_vld_d   = excl_vld_q;
    mem_cs_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    is_rd_d      = is_rd_q;
    oob_d        = oob_q;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    host_ack_d   = 1'b0;
    rd_data_d    = rd_data_q;
    host_rdata_d = host_rdata_q;
    age_d        = bus.host_req ? age_q : '0;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        excl_vld_d = 1'b0;
        if (any_ok) begin
          state_d     = S_ACCESS;
          gnt_d       = win;
          mem_cs_d    = !sel_oob;
          mem_we_d    = sel_we && !sel_oob;
          mem_addr_d  = sel_word;
          mem_wdata_d = sel_wdata;
          is_rd_d     = !sel_we;
          oob_d       = sel_oob;
          err_d       = err_q || sel_oob;
          if (bus.host_req) begin
            if (win == C_HOST)                 age_d = '0;
            else if (age_q < AGE_W'(HOST_AGE)) age_d = age_q + 1'b1;
          end
        end
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        state_d    = S_HOLD;
        excl_vld_d = 1'b1;
        case (gnt_q)
          C_WR: wr_ack_d = 1'b1;
          C_RD: begin
            rd_ack_d  = 1'b1;
            rd_data_d = resp_data;
          end
          C_HOST: begin
            host_ack_d = 1'b1;
            if (is_rd_q) host_rdata_d = resp_data;
          end
          default: ;
        endcase
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_q        <= C_WR;
      excl_vld_q   <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      is_rd_q      <= 1'b0;
      oob_q        <= 1'b0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      rd_data_q    <= '0;
      host_rdata_q <= '0;
      age_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      excl_vld_q   <= excl_vld_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      is_rd_q      <= is_rd_d;
      oob_q        <= oob_d;
      wr_ack_q     <= wr_ack_d;
      rd_ack_q     <= rd_ack_d;
      host_ack_q   <= host_ack_d;
      rd_data_q    <= rd_data_d;
      host_rdata_q <= host_rdata_d;
      age_q        <= age_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_cs      = mem_cs_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.vec_wr_ack  = wr_ack_q;
  assign bus.vec_rd_ack  = rd_ack_q;
  assign bus.vec_rd_data = rd_data_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_boreal_vec_mem_bridge.sv
// Directed bench for boreal_vec_mem_bridge: reset, single reads, contention order, host aging,
// handshake replay, out-of-range access and reset during an access, against a behavioural SRAM.
module tb_boreal_vec_mem_bridge;
  localparam int unsigned MEM_AW   = 12;
  localparam logic [31:0] MEM_BASE = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass   = 0;
  int   n_checks = 0;

  logic [31:0]       mem [0:(1<<MEM_AW)-1] = '{default: 32'd0};
  logic              tb_wr_en   = 1'b0;
  logic [MEM_AW-1:0] tb_wr_addr = '0;
  logic [31:0]       tb_wr_data = '0;

  boreal_vec_mem_bridge_if #(.MEM_AW(MEM_AW)) bus ();

  boreal_vec_mem_bridge #(.MEM_AW(MEM_AW), .MEM_BASE(MEM_BASE), .HOST_AGE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: read data appears the cycle after cs with we=0; bench port used for preloading.
  always @(posedge clk) begin
    if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
    else if (bus.mem_cs) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_reqs();
    bus.vec_rd_req  = 1'b0;
    bus.vec_rd_addr = '0;
    bus.vec_wr_req  = 1'b0;
    bus.vec_wr_addr = '0;
    bus.vec_wr_data = '0;
    bus.host_req    = 1'b0;
    bus.host_we     = 1'b0;
    bus.host_addr   = '0;
    bus.host_wdata  = '0;
  endtask

  initial begin
    clear_reqs();
    bus.mem_rdata = '0;

    // Reset values, with word 5 preloaded while reset is held.
    @(negedge clk);
    tb_wr_en = 1'b1; tb_wr_addr = 12'd5; tb_wr_data = 32'h1122_3344;
    @(negedge clk);
    tb_wr_en = 1'b0;
    check("rst_mem_cs",   32'(bus.mem_cs),     32'd0);
    check("rst_mem_we",   32'(bus.mem_we),     32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr),   32'd0);
    check("rst_wdata",    bus.mem_wdata,       32'd0);
    check("rst_acks",     32'({bus.vec_rd_ack, bus.vec_wr_ack, bus.host_ack}), 32'd0);
    check("rst_rd_data",  bus.vec_rd_data,     32'd0);
    check("rst_host_rd",  bus.host_rdata,      32'd0);
    check("rst_err",      32'(bus.err),        32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector read of word 5: cs at E1 with addr 5, ack and data at E2.
    bus.vec_rd_req = 1'b1; bus.vec_rd_addr = MEM_BASE + 32'h14;
    @(negedge clk);
    check("vrd_cs_e1",   32'(bus.mem_cs),   32'd1);
    check("vrd_addr_e1", 32'(bus.mem_addr), 32'd5);
    check("vrd_we_e1",   32'(bus.mem_we),   32'd0);
    @(negedge clk);
    check("vrd_cs_e2",   32'(bus.mem_cs),     32'd0);
    check("vrd_noack",   32'(bus.vec_rd_ack), 32'd0);
    @(negedge clk);
    check("vrd_ack",     32'(bus.vec_rd_ack), 32'd1);
    check("vrd_data",    bus.vec_rd_data,     32'h1122_3344);
    bus.vec_rd_req = 1'b0;
    @(negedge clk);
    check("vrd_ack_1cyc", 32'(bus.vec_rd_ack), 32'd0);
    @(negedge clk);

    // Host read with byte offset 3 lands on the same word.
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = MEM_BASE + 32'h17;
    for (int k = 1; k <= 3; k++) @(negedge clk);
    check("host_rd_ack",  32'(bus.host_ack), 32'd1);
    check("host_rd_data", bus.host_rdata,    32'h1122_3344);
    bus.host_req = 1'b0;
    @(negedge clk); @(negedge clk);

    // Contention on one address: wr, rd, host served in order; later reads see the write.
    begin
      int wr_c = -1, rd_c = -1, h_c = -1;
      logic [31:0] rd_val = '0, h_val = '0;
      bus.vec_wr_req = 1'b1; bus.vec_wr_addr = MEM_BASE + 32'h20; bus.vec_wr_data = 32'hA5A5_5A5A;
      bus.vec_rd_req = 1'b1; bus.vec_rd_addr = MEM_BASE + 32'h20;
      bus.host_req   = 1'b1; bus.host_we = 1'b0; bus.host_addr = MEM_BASE + 32'h20;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (bus.vec_wr_ack) begin wr_c = k - 1; bus.vec_wr_req = 1'b0; end
        if (bus.vec_rd_ack) begin rd_c = k - 1; rd_val = bus.vec_rd_data; bus.vec_rd_req = 1'b0; end
        if (bus.host_ack)   begin h_c  = k - 1; h_val  = bus.host_rdata;  bus.host_req   = 1'b0; end
      end
      check("cont_wr_cyc",   32'(wr_c), 32'd2);
      check("cont_rd_cyc",   32'(rd_c), 32'd6);
      check("cont_host_cyc", 32'(h_c),  32'd10);
      check("cont_rd_val",   rd_val,    32'hA5A5_5A5A);
      check("cont_host_val", h_val,     32'hA5A5_5A5A);
    end
    @(negedge clk);

    // Host aging: both vector clients stream, host write wins after 8 vector grants.
    begin
      int n_vec = 0, h_c = -1;
      bus.vec_wr_req = 1'b1; bus.vec_wr_addr = MEM_BASE + 32'h40; bus.vec_wr_data = 32'h0000_0077;
      bus.vec_rd_req = 1'b1; bus.vec_rd_addr = MEM_BASE + 32'h44;
      bus.host_req   = 1'b1; bus.host_we = 1'b1; bus.host_addr = MEM_BASE + 32'h48;
      bus.host_wdata = 32'hCAFE_F00D;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        if (bus.vec_wr_ack || bus.vec_rd_ack) n_vec++;
        if (bus.host_ack) begin h_c = k - 1; clear_reqs(); break; end
      end
      check("age_vec_grants", 32'(n_vec), 32'd8);
      check("age_host_cyc",   32'(h_c),   32'd34);
      for (int k = 0; k < 6; k++) @(negedge clk);
      check("age_host_write", mem[12'h12], 32'hCAFE_F00D);
      check("age_vec_write",  mem[12'h10], 32'h0000_0077);
      check("age_host_rdata_held", bus.host_rdata, 32'hA5A5_5A5A);
      check("age_vec_rdata",  bus.vec_rd_data, 32'd0);
    end

    // Handshake replay: req dropped one cycle after the ack -> one access, one ack.
    begin
      int n_cs = 0, n_ack = 0, drop_at = -1;
      bus.vec_wr_req = 1'b1; bus.vec_wr_addr = MEM_BASE + 32'h60; bus.vec_wr_data = 32'h600D_F00D;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (bus.mem_cs) n_cs++;
        if (bus.vec_wr_ack) begin n_ack++; drop_at = k + 1; end
        if (k == drop_at) bus.vec_wr_req = 1'b0;
      end
      bus.vec_wr_req = 1'b0;
      check("replay_cs_count",  32'(n_cs),  32'd1);
      check("replay_ack_count", 32'(n_ack), 32'd1);
      check("replay_data",      mem[12'h18], 32'h600D_F00D);
    end

    // Read one word past the top of the SRAM window.
    bus.vec_rd_req = 1'b1; bus.vec_rd_addr = MEM_BASE + 32'h4000;
    @(negedge clk);
`ifdef BOREAL_VMB_BOUNDS_EN
    check("oob_cs", 32'(bus.mem_cs), 32'd0);
`else
    check("oob_cs",   32'(bus.mem_cs),   32'd1);
    check("oob_addr", 32'(bus.mem_addr), 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    check("oob_ack", 32'(bus.vec_rd_ack), 32'd1);
`ifdef BOREAL_VMB_BOUNDS_EN
    check("oob_data", bus.vec_rd_data, 32'hDEAD_BEEF);
    check("oob_err",  32'(bus.err),    32'd1);
`else
    check("oob_data", bus.vec_rd_data, 32'd0);
    check("oob_err",  32'(bus.err),    32'd0);
`endif
    bus.vec_rd_req = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset while a write is in ACCESS: cs drops at once, no ack afterwards.
    begin
      int n_ack = 0;
      bus.vec_wr_req = 1'b1; bus.vec_wr_addr = MEM_BASE + 32'h80; bus.vec_wr_data = 32'hBAD0_0000;
      @(negedge clk);
      check("rst_acc_cs_before", 32'(bus.mem_cs), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_acc_cs_now", 32'(bus.mem_cs),  32'd0);
      check("rst_acc_err",    32'(bus.err),     32'd0);
      bus.vec_wr_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.vec_wr_ack) n_ack++;
      end
      check("rst_acc_no_ack", 32'(n_ack),        32'd0);
      check("rst_acc_state",  32'(dut.state_q),  32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/boreal_vec_mem_bridge.md
BOREAL_VEC_MEM_BRIDGE -- requirements
Module: boreal_vec_mem_bridge

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, meaning word-address width of the SRAM macro (depth 2^MEM_AW words).
REQ-002 SHALL have parameter MEM_BASE, default 32'h2000_0000, meaning byte address mapped to SRAM word 0.
REQ-003 SHALL have parameter HOST_AGE, default 8, meaning number of consecutive vector grants after which a waiting host request is forced to win.
REQ-004 Ports: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- vec_rd_req  in  1  vector read request, level, held until ack
- vec_rd_addr  in  32  vector read byte address
- vec_rd_data  out  32  read data, valid while vec_rd_ack=1
- vec_rd_ack  out  1  one-cycle read completion pulse
- vec_wr_req  in  1  vector write request, level
- vec_wr_addr  in  32  vector write byte address
- vec_wr_data  in  32  vector write data
- vec_wr_ack  out  1  one-cycle write completion pulse
- host_req / host_we  in  1/1  host request, write-enable
- host_addr / host_wdata  in  32/32  host byte address, write data
- host_rdata / host_ack  out  32/1  host read data, completion pulse
- mem_cs / mem_we  out  1/1  SRAM chip select, write enable
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid one cycle after cs with we=0
- err  out  1  sticky out-of-range flag (0 when BOREAL_VMB_BOUNDS_EN undefined)

Function
REQ-005 SHALL serialise three clients onto one single-port SRAM; one access in flight at a time.
REQ-006 FSM states IDLE, ACCESS, RESP, HOLD; IDLE->ACCESS on any eligible req; ACCESS->RESP unconditionally; RESP->HOLD unconditionally; HOLD->IDLE unconditionally.
REQ-007 In IDLE at edge E0, SHALL grant the winner, register mem_cs=1, mem_we, mem_addr=(addr-MEM_BASE)[MEM_AW+1:2], mem_wdata; addr[1:0] ignored.
REQ-008 At E1 (ACCESS) SHALL deassert mem_cs; at E2 (RESP) SHALL register mem_rdata into the granted client's data output (reads) and pulse the client's ack high for exactly one cycle (E2..E3).
REQ-009 Latency: ack visible 2 cycles after req first sampled in IDLE; throughput one access per 4 cycles.
REQ-010 HOLD SHALL exclude the just-acked client from arbitration for that cycle so its registered req deassertion is never re-served.
REQ-011 Priority: vec_wr > vec_rd > host, except when the host has been passed over HOST_AGE consecutive grants, then host wins and the age counter clears.
REQ-012 Age counter SHALL saturate at HOST_AGE and clear on host grant or when host_req=0.
REQ-013 Client data outputs SHALL hold their last value until the next read completes for that client.
REQ-014 Simultaneous read and write to same address from different clients SHALL be served in priority order; the later access observes the earlier one.

Reset
REQ-015 rst=1 SHALL asynchronously force state IDLE, mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0, all acks 0, vec_rd_data=0, host_rdata=0, age counter 0, err=0.
REQ-016 Reset during ACCESS SHALL abort the access (mem_cs low immediately; a write is not guaranteed to land); no ack SHALL be issued after reset release for the aborted access.

Configuration
REQ-017 Macro BOREAL_VMB_BOUNDS_EN defined: an access with addr<MEM_BASE or addr>=MEM_BASE+4*2^MEM_AW SHALL keep mem_cs=0, still ack on the normal schedule, return 32'hDEAD_BEEF for reads, drop writes, and set err sticky until reset.
REQ-018 Macro undefined: no range check; address wraps modulo SRAM depth; err tied 0.

Verification
REQ-019 Vector read: preload word 5 = 32'h1122_3344, vec_rd_req addr MEM_BASE+0x14 -> mem_cs at E1 with mem_addr=5, vec_rd_ack at E2 with vec_rd_data=32'h1122_3344.
REQ-020 Contention: vec_wr, vec_rd, host_req all asserted same cycle -> grant order wr, rd, host; acks at cycles 2, 6, 10.
REQ-021 Host aging, HOST_AGE=8: vector clients requesting continuously with host_req held -> host_ack after exactly 8 vector grants.
REQ-022 Vector-engine handshake replay: req held, deasserted one cycle after ack -> exactly one SRAM access per request, no duplicate ack.
REQ-023 Reset asserted in ACCESS of a write -> mem_cs 0 immediately, no vec_wr_ack after release, state IDLE.
REQ-024 With BOUNDS_EN: read MEM_BASE+0x4000 (MEM_AW=12) -> mem_cs stays 0, vec_rd_data=32'hDEAD_BEEF, err=1; without it, mem_addr=0.
